// File: rtl/rst_seq.sv
// Reset sequencer: releases STAGES reset outputs in ascending order, each gated by a
// synchronized ready/lock input with timeout, followed by a fixed settle delay.
module rst_seq #(
    parameter int STAGES    = 4,
    parameter int HOLD_CYC  = 16,
    parameter int STAGE_DLY = 1000,
    parameter int TIMEOUT   = 65535,
    parameter int CNT_W     = 16
) (
    input  logic              in_clk,
    input  logic              in_areset_n,
    input  logic              in_soft_rst,
    input  logic [STAGES-1:0] in_stage_ready,
    output logic [STAGES-1:0] out_reset,
    output logic              out_all_done,
    output logic              out_err,
    output logic [3:0]        out_err_stage
);

    typedef enum logic [2:0] {
        ST_HOLD,
        ST_WAIT_RDY,
        ST_DELAY,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(STAGE_DLY - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [3:0]       IDX_LAST  = 4'(STAGES - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        idx_q, idx_d;
    logic [STAGES-1:0] reset_q, reset_d;
    logic              all_done_q, all_done_d;
    logic              err_q, err_d;
    logic [3:0]        err_stage_q, err_stage_d;
    logic [STAGES-1:0] rdy_meta_q, rdy_meta_d;
    logic [STAGES-1:0] rdy_sync_q, rdy_sync_d;

    logic [STAGES-1:0] idx_mask;
    logic              rdy_sel;

    always_ff @(posedge in_clk or negedge in_areset_n) begin
        if (!in_areset_n) begin
            state_q     <= ST_HOLD;
            cnt_q       <= '0;
            idx_q       <= '0;
            reset_q     <= '1;
            all_done_q  <= 1'b0;
            err_q       <= 1'b0;
            err_stage_q <= '0;
            rdy_meta_q  <= '0;
            rdy_sync_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            reset_q     <= reset_d;
            all_done_q  <= all_done_d;
            err_q       <= err_d;
            err_stage_q <= err_stage_d;
            rdy_meta_q  <= rdy_meta_d;
            rdy_sync_q  <= rdy_sync_d;
        end
    end

    always_comb begin
        rdy_meta_d  = in_stage_ready;
        rdy_sync_d  = rdy_meta_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        reset_d     = reset_q;
        all_done_d  = all_done_q;
        err_d       = err_q;
        err_stage_d = err_stage_q;
        idx_mask    = STAGES'(1) << idx_q;
        rdy_sel     = |(rdy_sync_q & idx_mask);

        // Soft reset overrides every state, including loss of lock, timeout and release
        if (in_soft_rst) begin
            state_d     = ST_HOLD;
            cnt_d       = '0;
            idx_d       = '0;
            reset_d     = '1;
            all_done_d  = 1'b0;
            err_d       = 1'b0;
            err_stage_d = '0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d = ST_WAIT_RDY;
                        cnt_d   = '0;
                        idx_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_WAIT_RDY: begin
                    // Ready is tested before the timeout so a tie resolves to DELAY
                    if (rdy_sel) begin
                        state_d = ST_DELAY;
                        cnt_d   = '0;
                    end else if (cnt_q == TO_LAST) begin
                        state_d     = ST_ERR;
                        cnt_d       = '0;
                        err_d       = 1'b1;
                        err_stage_d = idx_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_DELAY: begin
                    if (cnt_q == DLY_LAST) begin
                        reset_d = reset_q & ~idx_mask;
                        cnt_d   = '0;
                        if (idx_q == IDX_LAST) begin
                            state_d    = ST_DONE;
                            all_done_d = 1'b1;
                        end else begin
                            state_d = ST_WAIT_RDY;
                            idx_d   = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!(&rdy_sync_q)) begin
                        state_d    = ST_HOLD;
                        cnt_d      = '0;
                        idx_d      = '0;
                        reset_d    = '1;
                        all_done_d = 1'b0;
                    end
                end
                ST_ERR: begin
                    state_d = ST_ERR;
                end
                default: begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                    idx_d   = '0;
                    reset_d = '1;
                end
            endcase
        end
    end

    assign out_reset     = reset_q;
    assign out_all_done  = all_done_q;
    assign out_err       = err_q;
    assign out_err_stage = err_stage_q;

endmodule

// File: tb/tb_rst_seq.sv
// Directed self-checking bench for rst_seq with STAGES=3, HOLD_CYC=4, STAGE_DLY=8, TIMEOUT=100.
module tb_rst_seq;

    localparam int STAGES = 3;

    logic              clk = 1'b0;
    logic              in_areset_n = 1'b1;
    logic              in_soft_rst = 1'b0;
    logic [STAGES-1:0] in_stage_ready = '1;
    logic [STAGES-1:0] out_reset;
    logic              out_all_done;
    logic              out_err;
    logic [3:0]        out_err_stage;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    rst_seq #(
        .STAGES   (3),
        .HOLD_CYC (4),
        .STAGE_DLY(8),
        .TIMEOUT  (100),
        .CNT_W    (16)
    ) dut (
        .in_clk        (clk),
        .in_areset_n   (in_areset_n),
        .in_soft_rst   (in_soft_rst),
        .in_stage_ready(in_stage_ready),
        .out_reset     (out_reset),
        .out_all_done  (out_all_done),
        .out_err       (out_err),
        .out_err_stage (out_err_stage)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vec_cnt++;
        if (observed !== expected) begin
            miss_cnt++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Returns just after the n-th rising edge, away from the active edge
    task automatic waitEdges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Holds async reset for two edges, checks the reset state, then releases it;
    // the next rising edge is edge 1 of the sequence
    task automatic applyReset(input string tag);
        in_areset_n = 1'b0;
        in_soft_rst = 1'b0;
        waitEdges(2);
        checkOutput({tag, "_rst_reset"}, 32'(out_reset), 32'h7);
        checkOutput({tag, "_rst_done"}, 32'(out_all_done), 32'h0);
        checkOutput({tag, "_rst_err"}, 32'(out_err), 32'h0);
        checkOutput({tag, "_rst_stage"}, 32'(out_err_stage), 32'h0);
        in_areset_n = 1'b1;
    endtask

    initial begin
        bit seen;

        #1;
        in_stage_ready = 3'b111;
        applyReset("nom");
        waitEdges(12);
        checkOutput("nom_e12_reset", 32'(out_reset), 32'h7);
        waitEdges(1);
        checkOutput("nom_e13_reset", 32'(out_reset), 32'h6);
        waitEdges(8);
        checkOutput("nom_e21_reset", 32'(out_reset), 32'h6);
        waitEdges(1);
        checkOutput("nom_e22_reset", 32'(out_reset), 32'h4);
        waitEdges(8);
        checkOutput("nom_e30_reset", 32'(out_reset), 32'h4);
        checkOutput("nom_e30_done", 32'(out_all_done), 32'h0);
        waitEdges(1);
        checkOutput("nom_e31_reset", 32'(out_reset), 32'h0);
        checkOutput("nom_e31_done", 32'(out_all_done), 32'h1);
        checkOutput("nom_e31_err", 32'(out_err), 32'h0);

        // Loss of lock in DONE: ready[0] low for five cycles
        in_stage_ready = 3'b110;
        waitEdges(2);
        checkOutput("lol_e2_reset", 32'(out_reset), 32'h0);
        waitEdges(1);
        checkOutput("lol_e3_reset", 32'(out_reset), 32'h7);
        checkOutput("lol_e3_done", 32'(out_all_done), 32'h0);
        checkOutput("lol_e3_err", 32'(out_err), 32'h0);
        waitEdges(2);
        in_stage_ready = 3'b111;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            waitEdges(1);
            if (out_all_done) seen = 1'b1;
        end
        checkOutput("lol_restart_done", 32'(out_all_done), 32'h1);
        checkOutput("lol_restart_reset", 32'(out_reset), 32'h0);

        // Soft reset held for three edges keeps the counter at zero
        in_soft_rst = 1'b1;
        waitEdges(1);
        checkOutput("shold_e1_reset", 32'(out_reset), 32'h7);
        checkOutput("shold_e1_done", 32'(out_all_done), 32'h0);
        waitEdges(2);
        in_soft_rst = 1'b0;
        waitEdges(30);
        checkOutput("shold_p30_done", 32'(out_all_done), 32'h0);
        waitEdges(1);
        checkOutput("shold_p31_done", 32'(out_all_done), 32'h1);

        // Late ready on stage 1
        in_stage_ready = 3'b101;
        applyReset("late");
        waitEdges(13);
        checkOutput("late_e13_reset", 32'(out_reset), 32'h6);
        waitEdges(50);
        in_stage_ready = 3'b111;
        waitEdges(10);
        checkOutput("late_r10_reset", 32'(out_reset), 32'h6);
        waitEdges(1);
        checkOutput("late_r11_reset", 32'(out_reset), 32'h4);
        waitEdges(9);
        checkOutput("late_done_reset", 32'(out_reset), 32'h0);
        checkOutput("late_done_done", 32'(out_all_done), 32'h1);

        // Timeout on stage 2, then recovery via soft reset
        in_stage_ready = 3'b011;
        applyReset("to");
        waitEdges(121);
        checkOutput("to_e121_err", 32'(out_err), 32'h0);
        checkOutput("to_e121_reset", 32'(out_reset), 32'h4);
        waitEdges(1);
        checkOutput("to_e122_err", 32'(out_err), 32'h1);
        checkOutput("to_e122_stage", 32'(out_err_stage), 32'h2);
        checkOutput("to_e122_reset", 32'(out_reset), 32'h4);
        checkOutput("to_e122_done", 32'(out_all_done), 32'h0);
        waitEdges(50);
        checkOutput("to_hold_err", 32'(out_err), 32'h1);
        checkOutput("to_hold_reset", 32'(out_reset), 32'h4);
        checkOutput("to_hold_done", 32'(out_all_done), 32'h0);

        in_stage_ready = 3'b111;
        waitEdges(2);
        in_soft_rst = 1'b1;
        waitEdges(1);
        checkOutput("rec_p0_reset", 32'(out_reset), 32'h7);
        checkOutput("rec_p0_err", 32'(out_err), 32'h0);
        checkOutput("rec_p0_stage", 32'(out_err_stage), 32'h0);
        in_soft_rst = 1'b0;
        waitEdges(30);
        checkOutput("rec_p30_reset", 32'(out_reset), 32'h4);
        checkOutput("rec_p30_done", 32'(out_all_done), 32'h0);
        waitEdges(1);
        checkOutput("rec_p31_reset", 32'(out_reset), 32'h0);
        checkOutput("rec_p31_done", 32'(out_all_done), 32'h1);
        checkOutput("rec_p31_err", 32'(out_err), 32'h0);

        // Ready for stage 2 arriving on the final timeout cycle wins
        in_stage_ready = 3'b011;
        applyReset("tie");
        waitEdges(119);
        in_stage_ready = 3'b111;
        waitEdges(3);
        checkOutput("tie_e122_err", 32'(out_err), 32'h0);
        waitEdges(7);
        checkOutput("tie_e129_reset", 32'(out_reset), 32'h4);
        waitEdges(1);
        checkOutput("tie_e130_reset", 32'(out_reset), 32'h0);
        checkOutput("tie_e130_done", 32'(out_all_done), 32'h1);
        checkOutput("tie_e130_err", 32'(out_err), 32'h0);

        // Async reset during stage 1 settle delay, between clock edges
        in_stage_ready = 3'b111;
        applyReset("async");
        waitEdges(16);
        checkOutput("async_e16_reset", 32'(out_reset), 32'h6);
        #3;
        in_areset_n = 1'b0;
        #1;
        checkOutput("async_imm_reset", 32'(out_reset), 32'h7);
        checkOutput("async_imm_done", 32'(out_all_done), 32'h0);
        applyReset("async2");
        waitEdges(12);
        checkOutput("async2_e12_reset", 32'(out_reset), 32'h7);
        waitEdges(1);
        checkOutput("async2_e13_reset", 32'(out_reset), 32'h6);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
